// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: opcodes, widths and the master state encoding.
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  // Slave select is driven low in every state that belongs to a frame.
  function automatic logic ss_active(input state_e s);
    return (s != ST_IDLE) && (s != ST_GAP);
  endfunction

endpackage

// File: rtl/spi_shift_ctr.sv
// 4-bit down-counter timing the fixed-length phases of a frame.
// Loading N-1 on entry to a phase makes done_o rise on the phase's last cycle.
module spi_shift_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit commands MSB-first on MOSI and, for RD_DATA
// commands, captures an 8-bit reply from MISO. One bit per clk; all outputs registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LAT   = 3,
  parameter int IDLE_GAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [CMD_W-1:0]    cmd_data,
  output logic                cmd_ready,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO
);

  localparam logic [3:0] SHIFT_LOAD = 4'd9;
  localparam logic [3:0] CAP_LOAD   = 4'd7;
  localparam logic [3:0] WAIT_LOAD  = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0] GAP_LOAD   = 4'(IDLE_GAP - 1);

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    shift_q, shift_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                ctr_load_s;
  logic [3:0]          ctr_val_s;
  logic                ctr_done_s;

  spi_shift_ctr u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ctr_load_s),
    .load_val_i (ctr_val_s),
    .done_o     (ctr_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the counter is loaded on every transition into a timed phase.
  always_comb begin
    state_d    = state_q;
    ctr_load_s = 1'b0;
    ctr_val_s  = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = ST_START;
        else           state_d = ST_IDLE;
      end
      ST_START: begin
        state_d    = ST_SHIFT;
        ctr_load_s = 1'b1;
        ctr_val_s  = SHIFT_LOAD;
      end
      ST_SHIFT: begin
        if (ctr_done_s) state_d = ST_HOLD;
        else            state_d = ST_SHIFT;
      end
      ST_HOLD: begin
        ctr_load_s = 1'b1;
        if (op_q == OP_RD_DATA) begin
          if (RD_LAT > 1) begin
            state_d   = ST_WAIT;
            ctr_val_s = WAIT_LOAD;
          end else begin
            state_d   = ST_CAPTURE;
            ctr_val_s = CAP_LOAD;
          end
        end else begin
          state_d   = ST_GAP;
          ctr_val_s = GAP_LOAD;
        end
      end
      ST_WAIT: begin
        if (ctr_done_s) begin
          state_d    = ST_CAPTURE;
          ctr_load_s = 1'b1;
          ctr_val_s  = CAP_LOAD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        if (ctr_done_s) begin
          state_d    = ST_GAP;
          ctr_load_s = 1'b1;
          ctr_val_s  = GAP_LOAD;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_GAP: begin
        if (ctr_done_s) state_d = ST_IDLE;
        else            state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next-values; pins are derived from the next state so they register cleanly.
  always_comb begin
    shift_d     = shift_q;
    op_d        = op_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          shift_d = cmd_data;
          op_d    = cmd_data[9:8];
        end else begin
          shift_d = shift_q;
        end
      end
      ST_SHIFT: shift_d = {shift_q[CMD_W-2:0], 1'b0};
      ST_CAPTURE: begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
        if (ctr_done_s) begin
          rsp_data_d  = {rx_q[DATA_W-2:0], MISO};
          rsp_valid_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      default: rx_d = rx_q;
    endcase
    ss_n_d  = ~ss_active(state_d);
    // START shows cmd[9] and the first SHIFT cycle repeats it, since shifting starts in SHIFT.
    mosi_d  = ((state_d == ST_START) || (state_d == ST_SHIFT)) ? shift_d[CMD_W-1] : 1'b0;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      op_q        <= 2'b00;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      shift_q     <= shift_d;
      op_q        <= op_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM model on the far side.
module tb_spi_master;

  localparam int RD_LAT   = 3;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = 10'h000;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];
  logic [7:0] s_addr  = 8'h00;
  logic [9:0] s_sreg  = 10'h000;
  logic [7:0] s_rbyte = 8'h00;
  int         s_fc    = 0;

  spi_master #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  // Slave model: counts frame cycles from SS_n falling, decodes the command on cycle 11,
  // and for RD_DATA drives the addressed byte MSB-first on the DUT's sample cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (SS_n) begin
        s_fc = 0;
        MISO = 1'b0;
      end else begin
        if (s_fc >= 1 && s_fc <= 10) s_sreg = {s_sreg[8:0], MOSI};
        if (s_fc == 11) begin
          case (s_sreg[9:8])
            2'b00, 2'b10: s_addr = s_sreg[7:0];
            2'b01:        mem[s_addr] = s_sreg[7:0];
            default:      s_rbyte = mem[s_addr];
          endcase
        end
        if (s_sreg[9:8] == 2'b11 && s_fc >= 11 + RD_LAT && s_fc <= 18 + RD_LAT)
          MISO = s_rbyte[18 + RD_LAT - s_fc];
        else
          MISO = 1'b0;
        s_fc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({SS_n, MOSI, cmd_ready, rsp_valid, busy} !== 5'b10100 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got ss/mosi/rdy/rv/busy=%b data=%h expected 10100 data=00",
               {SS_n, MOSI, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({SS_n, cmd_ready, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: got ss/rdy/busy=%b expected 110", {SS_n, cmd_ready, busy});
    end
  endtask

  task automatic test_wr_addr();
    logic [10:0] pat = 11'b00010100101;
    logic        e_ss, e_mosi, e_rdy;
    cmd_data  = 10'h0A5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      e_ss   = (c > 11);
      e_mosi = (c <= 10) ? pat[10 - c] : 1'b0;
      e_rdy  = (c >= 12 + IDLE_GAP);
      n_checks++;
      if ({SS_n, MOSI, cmd_ready, rsp_valid} !== {e_ss, e_mosi, e_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_addr cycle %0d: got ss/mosi/rdy/rv=%b expected %b",
                 c, {SS_n, MOSI, cmd_ready, rsp_valid}, {e_ss, e_mosi, e_rdy, 1'b0});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rd_data();
    logic [10:0] pat = 11'b11100000000;
    logic        e_ss, e_mosi, e_rdy, e_rv;
    mem[s_addr] = 8'hC3;
    cmd_data  = 10'h300;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 20 + RD_LAT + IDLE_GAP; c++) begin
      e_ss   = (c >= 19 + RD_LAT);
      e_mosi = (c <= 10) ? pat[10 - c] : 1'b0;
      e_rdy  = (c >= 19 + RD_LAT + IDLE_GAP);
      e_rv   = (c == 19 + RD_LAT);
      n_checks++;
      if ({SS_n, MOSI, cmd_ready, rsp_valid} !== {e_ss, e_mosi, e_rdy, e_rv}) begin
        n_fail++;
        $display("FAIL rd_data cycle %0d: got ss/mosi/rdy/rv=%b expected %b",
                 c, {SS_n, MOSI, cmd_ready, rsp_valid}, {e_ss, e_mosi, e_rdy, e_rv});
      end
      if (e_rv) begin
        n_checks++;
        if (rsp_data !== 8'hC3) begin
          n_fail++;
          $display("FAIL rd_data_value: got %h expected c3", rsp_data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL rd_data_hold: got %h expected c3", rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    localparam int B = 13 + IDLE_GAP;
    logic [10:0] pat;
    logic        e_ss, e_mosi, e_rdy;
    int          f;
    int          hi_cnt = 0;
    cmd_data  = 10'h012;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_data = 10'h1FF;
    for (int c = 0; c <= B + 12 + IDLE_GAP; c++) begin
      f      = (c < B) ? c : c - B;
      pat    = (c < B) ? 11'b00000010010 : 11'b00111111111;
      e_ss   = (f > 11);
      e_mosi = (f <= 10) ? pat[10 - f] : 1'b0;
      e_rdy  = (f >= 12 + IDLE_GAP);
      if (c < B && SS_n === 1'b1) hi_cnt++;
      n_checks++;
      if ({SS_n, MOSI, cmd_ready, rsp_valid} !== {e_ss, e_mosi, e_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got ss/mosi/rdy/rv=%b expected %b",
                 c, {SS_n, MOSI, cmd_ready, rsp_valid}, {e_ss, e_mosi, e_rdy, 1'b0});
      end
      if (c == B) cmd_valid = 1'b0;
      @(negedge clk);
    end
    // Between frames SS_n is high for the GAP cycles plus the IDLE handshake cycle.
    n_checks++;
    if (hi_cnt != IDLE_GAP + 1) begin
      n_fail++;
      $display("FAIL b2b_gap_len: got %0d expected %0d", hi_cnt, IDLE_GAP + 1);
    end
    n_checks++;
    if (rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_rsp_hold: got %h expected c3", rsp_data);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [10:0] pat = 11'b00100111100;
    logic        e_ss, e_mosi, e_rdy;
    cmd_data  = 10'h300;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (SS_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mfr_in_frame: got ss=%b expected 0", SS_n);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({SS_n, MOSI, cmd_ready, rsp_valid, busy} !== 5'b10100 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mfr_async: got ss/mosi/rdy/rv/busy=%b data=%h expected 10100 data=00",
               {SS_n, MOSI, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if ({SS_n, rsp_valid, cmd_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL mfr_quiet cycle %0d: got ss/rv/rdy=%b expected 101",
                 c, {SS_n, rsp_valid, cmd_ready});
      end
    end
    cmd_data  = 10'h13C;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      e_ss   = (c > 11);
      e_mosi = (c <= 10) ? pat[10 - c] : 1'b0;
      e_rdy  = (c >= 12 + IDLE_GAP);
      n_checks++;
      if ({SS_n, MOSI, cmd_ready, rsp_valid} !== {e_ss, e_mosi, e_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL mfr_new_frame cycle %0d: got ss/mosi/rdy/rv=%b expected %b",
                 c, {SS_n, MOSI, cmd_ready, rsp_valid}, {e_ss, e_mosi, e_rdy, 1'b0});
      end
      @(negedge clk);
    end
  endtask

  // Driver: handshake one command, report cycles until cmd_ready returns and any response.
  task automatic send_cmd(input logic [9:0] d, output int lat, output logic got,
                          output logic [7:0] data, output logic tmo);
    int k = 0;
    tmo = 1'b0; got = 1'b0; data = 8'h00; lat = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (cmd_ready !== 1'b1) begin
      if (rsp_valid === 1'b1) begin
        got  = 1'b1;
        data = rsp_data;
      end
      if (lat > 100) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_end_to_end();
    int         lat;
    logic       got, tmo;
    logic [7:0] data;
    send_cmd(10'h020, lat, got, data, tmo);
    n_checks++;
    if (tmo !== 1'b0 || got !== 1'b0 || lat != 13 + IDLE_GAP) begin
      n_fail++;
      $display("FAIL e2e_wr_addr: got tmo=%b rv=%b lat=%0d expected 0 0 %0d", tmo, got, lat, 13 + IDLE_GAP);
    end
    send_cmd(10'h15A, lat, got, data, tmo);
    n_checks++;
    if (tmo !== 1'b0 || got !== 1'b0) begin
      n_fail++;
      $display("FAIL e2e_wr_data: got tmo=%b rv=%b expected 0 0", tmo, got);
    end
    send_cmd(10'h220, lat, got, data, tmo);
    n_checks++;
    if (tmo !== 1'b0 || got !== 1'b0) begin
      n_fail++;
      $display("FAIL e2e_rd_addr: got tmo=%b rv=%b expected 0 0", tmo, got);
    end
    send_cmd(10'h300, lat, got, data, tmo);
    n_checks++;
    if (tmo !== 1'b0 || got !== 1'b1 || data !== 8'h5A || lat != 20 + RD_LAT + IDLE_GAP) begin
      n_fail++;
      $display("FAIL e2e_rd_data: got tmo=%b rv=%b data=%h lat=%0d expected 0 1 5a %0d",
               tmo, got, data, lat, 20 + RD_LAT + IDLE_GAP);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_wr_addr();
    test_rd_data();
    test_back_to_back();
    test_mid_frame_reset();
    test_end_to_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
